// File: rtl/sas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sas_pkg
//  Description : Shared types and default constants for the speed-alert
//                sequencing logic (state encoding, widths, cycle counts).
//  Revision    : 1.0 - initial release
// ============================================================================
package sas_pkg;

    // Controller states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TIMING   = 3'd1,
        ST_EVAL     = 3'd2,
        ST_DISPLAY  = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_t;

    // Default width of count / transit / timer values
    localparam int unsigned DEF_CW              = 32;

    // Default cycle constants shared with the speed-alert top level
    localparam int unsigned DEF_LIMIT_CYCLES    = 1_000_000;
    localparam int unsigned DEF_MAX_CYCLES      = 50_000_000;
    localparam int unsigned DEF_DISPLAY_CYCLES  = 100_000_000;
    localparam int unsigned DEF_COOLDOWN_CYCLES = 10_000_000;

endpackage : sas_pkg
`default_nettype wire

// File: rtl/speed_measure_ctrl_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : Registered single-bit rising-edge detector. The pulse is
//                valid for one cycle, one cycle after the input rises. The
//                first sample after reset only primes the history, so a level
//                already high when reset releases is never seen as an edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic edge_o
);

    logic prev_q;
    logic primed_q;
    logic edge_q;

    // Sample the level, prime after the first post-reset sample, register the edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q   <= 1'b0;
            primed_q <= 1'b0;
            edge_q   <= 1'b0;
        end else begin
            prev_q   <= sig_i;
            primed_q <= 1'b1;
            edge_q   <= primed_q & sig_i & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/speed_measure_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : speed_measure_ctrl
//  Description : Sequences the speed-alert datapath: arms/clears the transit
//                counter, times a vehicle between start and stop sensor
//                edges, compares against the limit, triggers the sign, and
//                enforces a cooldown lockout. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module speed_measure_ctrl
    import sas_pkg::*;
#(
    parameter int unsigned CW              = DEF_CW,
    parameter int unsigned LIMIT_CYCLES    = DEF_LIMIT_CYCLES,
    parameter int unsigned MAX_CYCLES      = DEF_MAX_CYCLES,
    parameter int unsigned DISPLAY_CYCLES  = DEF_DISPLAY_CYCLES,
    parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] count,
    output logic          count_reset,
    output logic          count_enable,
    output logic [CW-1:0] sign_timeout,
    output logic          sign_enable,
    output logic          speeding,
    output logic [CW-1:0] last_transit,
    output logic          busy
);

    localparam logic [CW-1:0] c_limit       = CW'(LIMIT_CYCLES);
    localparam logic [CW-1:0] c_max_last    = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] c_display     = CW'(DISPLAY_CYCLES);
    localparam logic [CW-1:0] c_display_end = CW'(DISPLAY_CYCLES - 1);
    localparam logic [CW-1:0] c_cool_end    = CW'(COOLDOWN_CYCLES - 1);

    logic start_e;
    logic stop_e;

    rise_detect u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (start),
        .edge_o (start_e)
    );

    rise_detect u_stop_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (stop),
        .edge_o (stop_e)
    );

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [CW-1:0] last_transit_q, last_transit_d;
    logic          speeding_q, speeding_d;
    logic          sign_enable_q, sign_enable_d;
    logic          count_reset_q, count_enable_q, busy_q;

    // Next-state, timer and measurement-result logic
    always_comb begin
        state_d        = state_q;
        timer_d        = '0;
        last_transit_d = last_transit_q;
        speeding_d     = speeding_q;
        sign_enable_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A stop edge, alone or together with start, is not a valid
                // approach and only triggers the lockout.
                if (stop_e) begin
                    state_d = ST_COOLDOWN;
                end else if (start_e) begin
                    state_d = ST_TIMING;
                end
            end
            ST_TIMING: begin
                // Stop takes priority over the abort threshold
                if (stop_e) begin
                    state_d        = ST_EVAL;
                    last_transit_d = count;
                end else if (count >= c_max_last) begin
                    state_d = ST_COOLDOWN;
                end
            end
            ST_EVAL: begin
                speeding_d = (last_transit_q < c_limit);
                if (speeding_d) begin
                    state_d       = ST_DISPLAY;
                    sign_enable_d = 1'b1;
                end else begin
                    state_d = ST_COOLDOWN;
                end
            end
            ST_DISPLAY: begin
                if (timer_q == c_display_end) begin
                    state_d = ST_COOLDOWN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (timer_q == c_cool_end) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, timer, results and Moore outputs decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            last_transit_q <= '0;
            speeding_q     <= 1'b0;
            sign_enable_q  <= 1'b0;
            count_reset_q  <= 1'b1;
            count_enable_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            last_transit_q <= last_transit_d;
            speeding_q     <= speeding_d;
            sign_enable_q  <= sign_enable_d;
            count_reset_q  <= (state_d != ST_TIMING) && (state_d != ST_EVAL);
            count_enable_q <= (state_d == ST_TIMING);
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    assign count_reset  = count_reset_q;
    assign count_enable = count_enable_q;
    assign sign_timeout = c_display;
    assign sign_enable  = sign_enable_q;
    assign speeding     = speeding_q;
    assign last_transit = last_transit_q;
    assign busy         = busy_q;

endmodule : speed_measure_ctrl
`default_nettype wire

// File: tb/tb_speed_measure_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_speed_measure_ctrl
//  Description : Self-checking bench for speed_measure_ctrl with an external
//                transit-counter model and a scoreboard of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_speed_measure_ctrl;

    localparam int CW   = 32;
    localparam int LIM  = 10;
    localparam int MAXC = 40;
    localparam int DISP = 8;
    localparam int COOL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic [CW-1:0] count;
    logic          count_reset;
    logic          count_enable;
    logic [CW-1:0] sign_timeout;
    logic          sign_enable;
    logic          speeding;
    logic [CW-1:0] last_transit;
    logic          busy;

    speed_measure_ctrl #(
        .CW              (CW),
        .LIMIT_CYCLES    (LIM),
        .MAX_CYCLES      (MAXC),
        .DISPLAY_CYCLES  (DISP),
        .COOLDOWN_CYCLES (COOL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .count        (count),
        .count_reset  (count_reset),
        .count_enable (count_enable),
        .sign_timeout (sign_timeout),
        .sign_enable  (sign_enable),
        .speeding     (speeding),
        .last_transit (last_transit),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // External transit counter model
    always @(posedge clk or posedge reset) begin
        if (reset)             count <= '0;
        else if (count_reset)  count <= '0;
        else if (count_enable) count <= count + 1;
    end

    typedef struct {
        int unsigned transit;
        bit          spd;
        int          pulses;
        int          busy_cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned model_transit = 0;
    bit          model_spd = 1'b0;

    localparam logic [68:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd8};

    task automatic wait_count(input int unsigned v, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (count == v) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s wait_count: count=%0d required %0d", name, count, v);
        end
    endtask

    task automatic test_reset();
        logic [68:0] got;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        #12;
        got = {count_reset, count_enable, sign_enable, speeding, busy, last_transit, sign_timeout};
        checks++;
        if (got !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", got, RESET_VEC);
        end
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || count_reset !== 1'b1 || count_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b count_reset=%b count_enable=%b required 0 1 0",
                     busy, count_reset, count_enable);
        end
    endtask

    // Complete measurement with stop edge landing while count == n
    task automatic test_vehicle(input int unsigned n, input string name);
        exp_t e;
        int cyc = 0, pulses = 0, pulse_at = 0, en_late = 0, stray = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_count(n - 1, name);
        stop = 1'b1;
        e.transit  = n;
        e.spd      = (n < LIM);
        e.pulses   = e.spd ? 1 : 0;
        e.busy_cyc = e.spd ? (2 + DISP + COOL) : (2 + COOL);
        sb.push_back(e);
        model_transit = n; model_spd = e.spd;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) stop = 1'b0;
            if (k == 4) start = 1'b1;
            if (k == 5) start = 1'b0;
            if (sign_enable) begin pulses++; pulse_at = k; end
            if (k >= 2 && count_enable) en_late++;
            if (!busy) break;
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (last_transit !== CW'(e.transit)) begin
            errors++; $display("FAIL %s last_transit: got %0d required %0d", name, last_transit, e.transit);
        end
        checks++;
        if (speeding !== e.spd) begin
            errors++; $display("FAIL %s speeding: got %b required %b", name, speeding, e.spd);
        end
        checks++;
        if (pulses != e.pulses) begin
            errors++; $display("FAIL %s sign_pulses: got %0d required %0d", name, pulses, e.pulses);
        end
        if (e.pulses == 1) begin
            checks++;
            if (pulse_at != 3) begin
                errors++; $display("FAIL %s sign_latency: got %0d required 3", name, pulse_at);
            end
        end
        checks++;
        if (cyc != e.busy_cyc) begin
            errors++; $display("FAIL %s busy_cycles: got %0d required %0d", name, cyc, e.busy_cyc);
        end
        checks++;
        if (en_late != 0) begin
            errors++; $display("FAIL %s enable_after_stop: got %0d required 0", name, en_late);
        end
        // Start edge issued during lockout must not launch a new measurement
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy || count_enable || !count_reset) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL %s idle_hold: got %0d busy cycles required 0", name, stray);
        end
    endtask

    // Start only: counter runs to MAX-1 and the measurement is discarded
    task automatic test_abort();
        exp_t e;
        int cyc = 0, en = 0, pulses = 0;
        e.transit = model_transit; e.spd = model_spd; e.pulses = 0; e.busy_cyc = MAXC + COOL;
        sb.push_back(e);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sign_enable) pulses++;
            if (count_enable) en++;
            if (!busy) break;
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (en != MAXC) begin
            errors++; $display("FAIL abort enable_cycles: got %0d required %0d", en, MAXC);
        end
        checks++;
        if (cyc != e.busy_cyc) begin
            errors++; $display("FAIL abort busy_cycles: got %0d required %0d", cyc, e.busy_cyc);
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL abort sign_pulses: got %0d required 0", pulses);
        end
        checks++;
        if (last_transit !== CW'(e.transit) || speeding !== e.spd) begin
            errors++; $display("FAIL abort hold: got %0d/%b required %0d/%b",
                               last_transit, speeding, e.transit, e.spd);
        end
    endtask

    // Stop alone, or stop together with start, only enters the lockout
    task automatic test_no_timing(input bit with_start, input string name);
        exp_t e;
        int cyc = 0, en = 0;
        e.transit = model_transit; e.spd = model_spd; e.pulses = 0; e.busy_cyc = COOL;
        sb.push_back(e);
        @(negedge clk); stop = 1'b1; start = with_start;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin stop = 1'b0; start = 1'b0; end
            if (count_enable) en++;
            if (k >= 2 && !busy) break;
            if (busy) cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (en != 0) begin
            errors++; $display("FAIL %s count_enable: got %0d cycles required 0", name, en);
        end
        checks++;
        if (cyc != e.busy_cyc) begin
            errors++; $display("FAIL %s busy_cycles: got %0d required %0d", name, cyc, e.busy_cyc);
        end
        checks++;
        if (last_transit !== CW'(e.transit) || speeding !== e.spd) begin
            errors++; $display("FAIL %s hold: got %0d/%b required %0d/%b",
                               name, last_transit, speeding, e.transit, e.spd);
        end
    endtask

    task automatic test_reset_mid_timing();
        logic [68:0] got;
        int stray = 0;
        @(negedge clk); start = 1'b1;
        wait_count(10, "reset_timing");
        #2 reset = 1'b1;
        #1 got = {count_reset, count_enable, sign_enable, speeding, busy, last_transit, sign_timeout};
        checks++;
        if (got !== RESET_VEC) begin
            errors++; $display("FAIL reset_mid_timing: got %h required %h", got, RESET_VEC);
        end
        model_transit = 0; model_spd = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy || count_enable) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL held_start_event: got %0d active cycles required 0", stray);
        end
        start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        checks++;
        if (count_enable !== 1'b0) begin
            errors++; $display("FAIL start_latency_early: got %b required 0", count_enable);
        end
        @(negedge clk);
        checks++;
        if (count_enable !== 1'b1) begin
            errors++; $display("FAIL start_latency: got %b required 1", count_enable);
        end
        start = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset_mid_display();
        logic [68:0] got;
        bit seen = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_count(4, "reset_display");
        stop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            stop = 1'b0;
            if (sign_enable) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL reset_display sign_wait: got 0 required 1");
        end
        @(negedge clk); @(negedge clk);
        checks++;
        if (speeding !== 1'b1 || last_transit !== CW'(5)) begin
            errors++; $display("FAIL reset_display pre: got %b/%0d required 1/5", speeding, last_transit);
        end
        #2 reset = 1'b1;
        #1 got = {count_reset, count_enable, sign_enable, speeding, busy, last_transit, sign_timeout};
        checks++;
        if (got !== RESET_VEC) begin
            errors++; $display("FAIL reset_mid_display: got %h required %h", got, RESET_VEC);
        end
        model_transit = 0; model_spd = 1'b0;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vehicle(6,  "fast");
        test_vehicle(25, "slow");
        test_vehicle(10, "boundary10");
        test_vehicle(9,  "boundary9");
        test_abort();
        test_vehicle(39, "stop_wins");
        test_no_timing(1'b0, "reverse");
        test_no_timing(1'b1, "simultaneous");
        test_reset_mid_timing();
        test_reset_mid_display();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_speed_measure_ctrl
`default_nettype wire

// File: doc/speed_measure_ctrl.md
Name: speed_measure_ctrl

Overview:
- Sequences the speed-alert datapath: arms and clears the transit counter, times a vehicle between sensor start and stop events, and compares the transit time against the limit.
- Drives the sign with a display duration when the vehicle is speeding.
- Sits between the sensor interface (start/stop) and the counter/sign blocks inside the speed-alert top level.
- Adds abort-on-timeout, cooldown lockout and status outputs.

Parameters:
- CW, 32, width of count, transit and timeout values.
- LIMIT_CYCLES, 1_000_000, transit strictly below this means speeding.
- MAX_CYCLES, 50_000_000, transit abort threshold; no stop by then means the measurement is discarded.
- DISPLAY_CYCLES, 100_000_000, sign on-time; driven on sign_timeout and also timed internally.
- COOLDOWN_CYCLES, 10_000_000, post-measurement lockout during which sensor events are ignored.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  level from sensor interface, first sensor tripped
- stop  input  1  level from sensor interface, second sensor tripped
- count  input  CW  current value of the external transit counter
- count_reset  output  1  synchronous clear request to the counter
- count_enable  output  1  counter increment enable
- sign_timeout  output  CW  display duration for the sign
- sign_enable  output  1  one-cycle trigger to the sign
- speeding  output  1  registered result of the last valid measurement
- last_transit  output  CW  latched transit count of the last valid measurement
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async) sets the following until the first clk edge after deassertion:
  - state IDLE; count_reset=1; count_enable=0; sign_enable=0
  - sign_timeout=DISPLAY_CYCLES (constant); speeding=0; last_transit=0; busy=0
  - internal timer=0; edge-detect history=0
- Edge detection:
  - start and stop are registered; start_e/stop_e are rising edges, valid one cycle after the input rises.
  - Inputs held high produce no further events.
- States, with Moore outputs from registered state:
  - IDLE: count_reset=1, count_enable=0.
    - start_e alone -> TIMING.
    - stop_e alone (reverse direction) -> COOLDOWN.
    - start_e and stop_e in the same cycle -> COOLDOWN (invalid).
  - TIMING: count_reset=0, count_enable=1.
    - stop_e -> EVAL, with last_transit<=count on that cycle.
    - Else count>=MAX_CYCLES-1 -> COOLDOWN with no sign and speeding unchanged.
    - stop_e wins over a timeout in the same cycle.
    - start_e is ignored (no retrigger).
  - EVAL: one cycle, count_enable=0.
    - speeding<=(last_transit<LIMIT_CYCLES).
    - If speeding -> DISPLAY, with sign_enable=1 on the EVAL->DISPLAY transition cycle only.
    - Else -> COOLDOWN.
  - DISPLAY: timer counts 0..DISPLAY_CYCLES-1, then -> COOLDOWN; timer cleared on every state change.
  - COOLDOWN: count_reset=1; timer counts 0..COOLDOWN_CYCLES-1, then -> IDLE.
- Sensor edges are ignored in EVAL, DISPLAY and COOLDOWN.
- last_transit and speeding change only in TIMING->EVAL and EVAL respectively, and hold otherwise.
- Width rules:
  - All compares are unsigned CW-bit.
  - Timer is CW bits and never wraps, because it exits at its terminal value.
  - Parameters must be >=1; LIMIT_CYCLES<=MAX_CYCLES.
- Latency:
  - start rise to count_enable=1 is 2 cycles (edge register plus state register).
  - stop rise to sign_enable pulse is 3 cycles.
- Reset mid-operation returns all outputs to reset values immediately; no partial measurement survives.

Decomposition:
- Package sas_pkg holds:
  - state enum (IDLE, TIMING, EVAL, DISPLAY, COOLDOWN)
  - CW default
  - default cycle constants shared with the top level
- One sub-module, rise_detect: single-bit registered rising-edge detector with async reset, instantiated twice (start, stop).

Test Plan:
All scenarios use the external counter model with LIMIT=10, MAX=40, DISPLAY=8, COOLDOWN=4.
- Fast vehicle: start rise, stop rise with count=6 -> last_transit=6, speeding=1, single sign_enable pulse, busy for 8 DISPLAY + 4 COOLDOWN cycles, then IDLE with count_reset=1.
- Slow vehicle: stop rise with count=25 -> last_transit=25, speeding=0, no sign_enable, 4 COOLDOWN cycles, then IDLE.
- Boundary: transit count=10 gives speeding=0; count=9 gives speeding=1.
- Abort: start only -> count reaches 39, state goes to COOLDOWN, no sign_enable, last_transit/speeding keep prior values. A stop edge on the same cycle as count=39 must instead take EVAL.
- Reverse and simultaneous:
  - stop before start in IDLE -> COOLDOWN, count_enable never asserted.
  - start and stop rising in the same cycle -> COOLDOWN.
  - start edges during DISPLAY/COOLDOWN are ignored.
- Async reset asserted mid-TIMING and mid-DISPLAY -> all outputs at reset values before the next clk edge. A held-high start after release produces no event until it falls and rises again.
